// File: rtl/console_pkg.sv
// console_pkg: shared definitions for the MMIO console block.
//   - register offsets (word index taken from mem_addr[3:2])
//   - STATUS register bit positions
//   - TX FSM state encoding
package console_pkg;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_TOHOST = 2'd2;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/console_fifo.sv
// console_fifo: synchronous byte FIFO, no bypass (a pushed byte is visible
// on dout from the following cycle).
// Ports:
//   clk, reset      clock, synchronous active-high reset (empties the FIFO)
//   push, din       write strobe and byte; ignored when full
//   pop             read strobe; ignored when empty
//   dout            head entry (valid while !empty)
//   full, empty     occupancy flags
//   count           entries held, 0..DEPTH
module console_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign dout  = mem[rptr];
  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/mmio_console.sv
// mmio_console: slave on the CPU data-memory port.
//   TXDATA (0x0) store queues a byte for the UART transmitter,
//   STATUS (0x4) reports FIFO/transmitter state,
//   TOHOST (0x8) latches the first exit code and raises a sticky halt.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   mem_req/we/addr/wdata           CPU access
//   mem_ready                       0 only for a TXDATA store hitting a full FIFO
//   mem_rvalid/mem_rdata            load response, one cycle after accept
//   uart_tx                         8N1 serial out, idle high
//   halt, exit_code                 tohost handshake to the bench
module mmio_console
  import console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          CLKS_PER_BIT = 8,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic        uart_tx,
  output logic        halt,
  output logic [31:0] exit_code
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  // ---------------- bus decode ----------------
  logic       hit, st_tx, st_host, ld_acc;
  logic [1:0] ofs;
  logic       unused_addr_lsbs;

  assign unused_addr_lsbs = ^mem_addr[1:0];
  assign hit     = mem_req && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign ofs     = mem_addr[3:2];
  assign st_tx   = hit && mem_we && (ofs == OFS_TXDATA);
  assign st_host = hit && mem_we && (ofs == OFS_TOHOST);
  assign ld_acc  = hit && !mem_we;   // loads never stall

  // ---------------- FIFO ----------------
  logic          fifo_full, fifo_empty, fifo_pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;

  // Stall keys off the registered full flag, so a pop in the same cycle
  // does not rescue the store; it is taken on the next cycle.
  assign mem_ready = !(st_tx && fifo_full);

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (st_tx && !fifo_full),
    .din   (mem_wdata[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ---------------- TX FSM ----------------
  tx_state_e     state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    tx_byte;

  assign fifo_pop = (state == TX_IDLE) && !fifo_empty;

  // uart_tx is loaded on each state/bit transition so the line is glitch
  // free and each level lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      tx_byte <= '0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          baud    <= '0;
          uart_tx <= 1'b1;
          if (!fifo_empty) begin
            tx_byte <= fifo_dout;
            uart_tx <= 1'b0;
            state   <= TX_START;
          end
        end
        TX_START: begin
          if (baud == BAUD_LAST) begin
            baud    <= '0;
            bit_idx <= '0;
            uart_tx <= tx_byte[0];
            state   <= TX_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= TX_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= tx_byte[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin // TX_STOP
          if (baud == BAUD_LAST) begin
            baud  <= '0;
            state <= TX_IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- load path and tohost ----------------
  logic [31:0] status, rd_mux;

  always_comb begin
    status = '0;
    status[ST_FULL]              = fifo_full;
    status[ST_EMPTY]             = fifo_empty;
    status[ST_BUSY]              = (state != TX_IDLE);
    status[ST_CNT_LSB +: CW]     = fifo_count;
  end

  always_comb begin
    rd_mux = '0;
    case (ofs)
      OFS_STATUS: rd_mux = status;
      OFS_TOHOST: rd_mux = exit_code;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      halt       <= 1'b0;
      exit_code  <= '0;
    end else begin
      mem_rvalid <= ld_acc;
      mem_rdata  <= ld_acc ? rd_mux : '0;
      // Only the first tohost write counts.
      if (st_host && !halt) begin
        halt      <= 1'b1;
        exit_code <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mmio_console.sv
module tb_mmio_console;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_req = 1'b0, mem_we = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        mem_ready, mem_rvalid, uart_tx, halt;
  logic [31:0] mem_rdata, exit_code;

  mmio_console #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .uart_tx(uart_tx),
    .halt(halt), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Reference model state: bytes accepted but not yet seen on the line.
  logic [7:0] exp_q[$];
  int         starts_q[$];
  int         cyc = 0, mon_t = 0;
  bit         mon_en = 0, mon_busy = 0;
  logic [7:0] mon_byte;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART line decoder: samples mid-bit, compares each byte against the queue.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!mon_busy) begin
      if (mon_en && uart_tx === 1'b0) begin
        mon_busy = 1; mon_t = 0; mon_byte = '0;
        starts_q.push_back(cyc);
      end
    end else begin
      mon_t++;
      if (mon_t == CPB/2) chk("start_bit", {31'b0, uart_tx}, 0);
      if (mon_t >= CPB && mon_t < 9*CPB && (mon_t % CPB) == CPB/2)
        mon_byte[mon_t/CPB - 1] = uart_tx;
      if (mon_t == 9*CPB + CPB/2) chk("stop_bit", {31'b0, uart_tx}, 1);
      if (mon_t == 10*CPB - 1) begin
        mon_busy = 0;
        if (exp_q.size() == 0) chk("unexpected_byte", {24'b0, mon_byte}, 32'hffff_ffff);
        else chk("rx_byte", {24'b0, mon_byte}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    logic r;
    stalls = 0;
    mem_req = 1; mem_we = 1; mem_addr = a; mem_wdata = d;
    forever begin
      #1 r = mem_ready;
      @(posedge clk);
      if (r === 1'b1) break;
      stalls++;
      if (stalls > 500) begin chk("store_timeout", 1, 0); break; end
      @(negedge clk);
    end
    if (r === 1'b1 && a[31:4] == BASE[31:4] && a[3:2] == 2'd0) exp_q.push_back(d[7:0]);
    @(negedge clk);
    mem_req = 0; mem_we = 0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic v, output logic [31:0] d);
    mem_req = 1; mem_we = 0; mem_addr = a;
    #1 chk("load_ready", {31'b0, mem_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    mem_req = 0;
    v = mem_rvalid; d = mem_rdata;
    @(negedge clk);
    chk("rvalid_one_cycle", {31'b0, mem_rvalid}, 0);
    chk("rdata_idle_zero", mem_rdata, 0);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < limit) begin @(negedge clk); n++; end
    chk("drain", {31'b0, (exp_q.size() == 0 && !mon_busy)}, 1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_v;
    logic [31:0] exp_d;
  } vec_t;
  vec_t vt[10];

  initial begin
    logic        v, e;
    logic [31:0] d, a;
    logic [7:0]  b;
    int          st, lows, op;
    int          stall_k[6];
    logic [31:0] m_exit;

    vt[0] = '{0, BASE + 32'h8,  32'h0,       1, 32'h1};
    vt[1] = '{0, BASE + 32'h0,  32'h0,       1, 32'h0};
    vt[2] = '{0, BASE + 32'hC,  32'h0,       1, 32'h0};
    vt[3] = '{1, BASE + 32'hC,  32'hdead,    0, 32'h0};
    vt[4] = '{0, BASE + 32'hC,  32'h0,       1, 32'h0};
    vt[5] = '{0, 32'h2000_0008, 32'h0,       0, 32'h0};
    vt[6] = '{1, BASE + 32'h8,  32'h9,       0, 32'h0};
    vt[7] = '{0, BASE + 32'h8,  32'h0,       1, 32'h1};
    vt[8] = '{0, BASE + 32'h14, 32'h0,       0, 32'h0};
    vt[9] = '{0, BASE + 32'h4,  32'h0,       1, 32'h2};

    // ---- reset values ----
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", {31'b0, uart_tx}, 1);
    chk("rst_halt", {31'b0, halt}, 0);
    chk("rst_exit_code", exit_code, 0);
    chk("rst_rvalid", {31'b0, mem_rvalid}, 0);
    chk("rst_rdata", mem_rdata, 0);
    reset = 0;
    mon_en = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_uart_tx", {31'b0, uart_tx}, 1);
      chk("idle_halt", {31'b0, halt}, 0);
      chk("idle_rvalid", {31'b0, mem_rvalid}, 0);
    end

    // ---- STATUS right after reset: empty, count 0 ----
    do_load(BASE + 32'h4, v, d);
    chk("status_rst_v", {31'b0, v}, 1);
    chk("status_rst_d", d, 32'h2);

    // ---- single frame 0x41, exact waveform ----
    b = 8'h41;
    do_store(BASE, 32'h41, st);
    chk("store41_stall", st, 0);
    for (int i = 0; i <= 10*CPB + 1; i++) begin
      if (i == 0) e = 1'b1;
      else if (i <= CPB) e = 1'b0;
      else if (i <= 9*CPB) e = b[(i - CPB - 1) / CPB];
      else e = 1'b1;
      chk("frame41_tx", {31'b0, uart_tx}, {31'b0, e});
      @(negedge clk);
    end
    drain(200);

    // ---- tx_busy during a frame ----
    do_store(BASE, 32'h55, st);
    repeat (10) @(negedge clk);
    do_load(BASE + 32'h4, v, d);
    chk("status_busy", d, 32'h6);
    drain(200);

    // ---- burst: fill FIFO, sixth store stalls until the next pop ----
    starts_q.delete();
    for (int k = 0; k < 6; k++) do_store(BASE, 32'h30 + k, stall_k[k]);
    for (int k = 0; k < 5; k++) chk("burst_nostall", stall_k[k], 0);
    chk("burst_stall_len", stall_k[5], 10*CPB - 2);
    drain(1000);
    chk("burst_frames", starts_q.size(), 6);
    for (int k = 0; k + 1 < starts_q.size(); k++)
      chk("burst_gap", starts_q[k+1] - starts_q[k], 10*CPB + 1);

    // ---- tohost ----
    chk("pre_halt", {31'b0, halt}, 0);
    do_store(BASE + 32'h8, 32'h1, st);
    chk("halt_set", {31'b0, halt}, 1);
    chk("exit_first", exit_code, 1);
    do_store(BASE + 32'h8, 32'h7, st);
    chk("exit_sticky", exit_code, 1);
    do_load(BASE + 32'h8, v, d);
    chk("tohost_load", d, 1);
    m_exit = 32'h1;

    // ---- table vectors ----
    for (int i = 0; i < 10; i++) begin
      if (vt[i].we) begin
        do_store(vt[i].addr, vt[i].wdata, st);
        chk("vec_store_ready", st, 0);
      end else begin
        do_load(vt[i].addr, v, d);
        chk("vec_rvalid", {31'b0, v}, {31'b0, vt[i].exp_v});
        chk("vec_rdata", d, vt[i].exp_d);
      end
    end

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 7);
      a = $urandom();
      if (a[31:4] == BASE[31:4]) a = a ^ 32'h8000_0000;
      case (op)
        0: begin do_load(BASE + 32'h8, v, d); chk("rnd_tohost", d, m_exit); end
        1: begin do_load(BASE + 32'h0, v, d); chk("rnd_txdata_rd", {v, d[30:0]}, 32'h8000_0000); end
        2: begin do_load(BASE + 32'hC, v, d); chk("rnd_rsvd_rd", {v, d[30:0]}, 32'h8000_0000); end
        3: begin
             do_store(BASE + 32'h8, $urandom(), st);
             chk("rnd_exit_hold", exit_code, m_exit);
             chk("rnd_halt_hold", {31'b0, halt}, 1);
           end
        4: begin do_load(a, v, d); chk("rnd_miss_ld", {31'b0, v}, 0); end
        5: begin do_store(a, $urandom(), st); chk("rnd_miss_st", st, 0); end
        6: begin do_store(BASE + 32'hC, $urandom(), st); chk("rnd_rsvd_st", st, 0); end
        default: if ($urandom_range(0, 2) == 0) do_store(BASE, $urandom(), st);
      endcase
    end
    drain(3000);
    chk("halt_still", {31'b0, halt}, 1);

    // ---- reset in the middle of DATA bit 3 with bytes queued ----
    do_store(BASE, 32'hA5, st);
    do_store(BASE, 32'h5A, st);
    do_store(BASE, 32'hFF, st);
    repeat (16) @(negedge clk);
    chk("pre_reset_bit3", {31'b0, uart_tx}, 0);
    @(posedge clk);
    #1;
    mon_en = 0; mon_busy = 0; exp_q.delete();
    reset = 1;
    @(posedge clk);
    #1;
    chk("midrst_uart_tx", {31'b0, uart_tx}, 1);
    chk("midrst_halt", {31'b0, halt}, 0);
    chk("midrst_exit", exit_code, 0);
    @(negedge clk);
    reset = 0;
    do_load(BASE + 32'h4, v, d);
    chk("midrst_status", d, 32'h2);
    lows = 0;
    repeat (120) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("midrst_no_frames", lows, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
